// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit direction counters; BTP_STATS_EN adds update statistics
module branch_target_predictor #(
  parameter int         ENTRIES  = 16,
  parameter int         PC_W     = 32,
  parameter logic [1:0] CTR_INIT = 2'b10
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            predict_hit,
  output logic            predict_taken,
  output logic [PC_W-1:0] predict_target,
  input  logic            update_en,
  input  logic [PC_W-1:0] update_pc,
  input  logic            update_taken,
  input  logic [PC_W-1:0] update_target,
  input  logic            update_mispredict,
  output logic            busy
`ifdef BTP_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state, next_state;
  logic [IDX_W-1:0]   sweep_idx;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [PC_W-1:0]    target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  logic [IDX_W-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0]   l_tag, u_tag;
  logic               u_hit, upd_fire;
  logic               unused_bits;

  assign unused_bits = ^{update_pc[1:0], update_mispredict};

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[PC_W-1:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[PC_W-1:IDX_W+2];

  assign busy     = (state == SWEEP);
  assign u_hit    = valid[u_idx] && (tag_mem[u_idx] == u_tag);
  // The reset cycle drops any update presented alongside it.
  assign upd_fire = update_en && !busy && !nRST;

  always_comb begin
    predict_hit    = 1'b0;
    predict_taken  = 1'b0;
    predict_target = lookup_pc + PC_W'(4);
    if (!busy && valid[l_idx] && (tag_mem[l_idx] == l_tag)) begin
      predict_hit = 1'b1;
      if (ctr_mem[l_idx][1]) begin
        predict_taken  = 1'b1;
        predict_target = target_mem[l_idx];
      end
    end
  end

  always_comb begin
    next_state = state;
    if (state == SWEEP && sweep_idx == IDX_W'(ENTRIES - 1)) next_state = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state     <= SWEEP;
      sweep_idx <= '0;
    end else begin
      state     <= next_state;
      if (state == SWEEP) sweep_idx <= sweep_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (state == SWEEP) valid[sweep_idx] <= 1'b0;
    else if (upd_fire && !u_hit && update_taken) valid[u_idx] <= 1'b1;
  end

  // Payload storage carries no reset; the valid bit guards it.
  always_ff @(posedge CLK) begin
    if (upd_fire) begin
      if (u_hit) begin
        if (update_taken) begin
          target_mem[u_idx] <= update_target;
          if (ctr_mem[u_idx] != 2'b11) ctr_mem[u_idx] <= ctr_mem[u_idx] + 2'b01;
        end else if (ctr_mem[u_idx] != 2'b00) begin
          ctr_mem[u_idx] <= ctr_mem[u_idx] - 2'b01;
        end
      end else if (update_taken) begin
        tag_mem[u_idx]    <= u_tag;
        target_mem[u_idx] <= update_target;
        ctr_mem[u_idx]    <= CTR_INIT;
      end
    end
  end

`ifdef BTP_STATS_EN
  always_ff @(posedge CLK) begin
    if (nRST) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else if (upd_fire) begin
      stat_lookups <= stat_lookups + 32'd1;
      if (u_hit) stat_hits <= stat_hits + 32'd1;
      if (update_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed self-checking bench for branch_target_predictor
module tb_branch_target_predictor;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] lookup_pc;
  logic        predict_hit, predict_taken;
  logic [31:0] predict_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        busy;
`ifdef BTP_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

  int checks = 0;
  int fails  = 0;

  branch_target_predictor #(.ENTRIES(16), .PC_W(32), .CTR_INIT(2'b10)) dut (
    .CLK(CLK), .nRST(nRST),
    .lookup_pc(lookup_pc), .predict_hit(predict_hit), .predict_taken(predict_taken),
    .predict_target(predict_target),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .busy(busy)
`ifdef BTP_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
    update_en = 1'b1; update_pc = pc; update_taken = tk; update_target = tgt; update_mispredict = mp;
    tick();
    update_en = 1'b0; update_pc = 'x; update_taken = 1'bx; update_target = 'x; update_mispredict = 1'bx;
  endtask

  task automatic expect_lookup(input string name, input logic [31:0] pc,
                               input logic hit, input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    checks++;
    if (predict_hit !== hit || predict_taken !== tk || predict_target !== tgt) begin
      fails++;
      $display("FAIL %s pc=%h got hit=%b taken=%b target=%h, expected hit=%b taken=%b target=%h",
               name, pc, predict_hit, predict_taken, predict_target, hit, tk, tgt);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1; update_en = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; update_mispredict = 1'b0; lookup_pc = 32'h40;
    tick(); tick();
    nRST = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy cycle %0d busy=%b expected 1", i, busy); end
      checks++;
      if (predict_hit !== 1'b0 || predict_target !== 32'h44) begin
        fails++;
        $display("FAIL reset_lookup cycle %0d hit=%b target=%h expected hit=0 target=00000044", i, predict_hit, predict_target);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy_drop busy=%b expected 0", busy); end
`ifdef BTP_STATS_EN
    checks++;
    if (stat_lookups !== 0 || stat_hits !== 0 || stat_mispredicts !== 0) begin
      fails++;
      $display("FAIL stats_reset got %0d/%0d/%0d expected 0/0/0", stat_lookups, stat_hits, stat_mispredicts);
    end
`endif
  endtask

  task automatic test_allocate();
    lookup_pc = 32'h100;
    update_en = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h200; update_mispredict = 1'b0;
    #1;
    checks++;
    if (predict_hit !== 1'b0 || predict_target !== 32'h104) begin
      fails++;
      $display("FAIL alloc_same_cycle hit=%b target=%h expected hit=0 target=00000104", predict_hit, predict_target);
    end
    tick();
    update_en = 1'b0; update_pc = 'x; update_taken = 1'bx; update_target = 'x;
    expect_lookup("alloc_next_cycle", 32'h100, 1'b1, 1'b1, 32'h200);
  endtask

  task automatic test_saturation();
    logic        tk_seq  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        exp_tk  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp_tgt [6] = '{32'h200, 32'h200, 32'h200, 32'h104, 32'h104, 32'h104};
    for (int i = 0; i < 6; i++) begin
      do_update(32'h100, tk_seq[i], 32'h200, 1'b0);
      expect_lookup($sformatf("saturation_step%0d", i), 32'h100, 1'b1, exp_tk[i], exp_tgt[i]);
    end
  endtask

  task automatic test_alias();
    do_update(32'h140, 1'b1, 32'h300, 1'b0);
    expect_lookup("alias_old_miss", 32'h100, 1'b0, 1'b0, 32'h104);
    expect_lookup("alias_new_hit", 32'h140, 1'b1, 1'b1, 32'h300);
  endtask

  task automatic test_miss_wrap();
    do_update(32'h500, 1'b0, 32'h900, 1'b0);
    expect_lookup("nt_miss_no_alloc", 32'h500, 1'b0, 1'b0, 32'h504);
    expect_lookup("nt_miss_keeps_entry", 32'h140, 1'b1, 1'b1, 32'h300);
    expect_lookup("wrap_target", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    int n;
    do_update(32'h144, 1'b1, 32'h400, 1'b0);
    do_update(32'h188, 1'b1, 32'h500, 1'b0);
    expect_lookup("populate_144", 32'h144, 1'b1, 1'b1, 32'h400);
    nRST = 1'b1;
    update_en = 1'b1; update_pc = 32'h100; update_taken = 1'b1; update_target = 32'h600; update_mispredict = 1'b1;
    tick();
    nRST = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin tick(); n++; end
    update_en = 1'b0;
    checks++;
    if (busy !== 1'b0 || n != 16) begin
      fails++;
      $display("FAIL midreset_sweep busy=%b after %0d cycles expected busy=0 after 16", busy, n);
    end
    expect_lookup("midreset_100", 32'h100, 1'b0, 1'b0, 32'h104);
    expect_lookup("midreset_140", 32'h140, 1'b0, 1'b0, 32'h144);
    expect_lookup("midreset_144", 32'h144, 1'b0, 1'b0, 32'h148);
    expect_lookup("midreset_188", 32'h188, 1'b0, 1'b0, 32'h18C);
`ifdef BTP_STATS_EN
    checks++;
    if (stat_lookups !== 0 || stat_hits !== 0 || stat_mispredicts !== 0) begin
      fails++;
      $display("FAIL midreset_stats got %0d/%0d/%0d expected 0/0/0", stat_lookups, stat_hits, stat_mispredicts);
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_update(32'h100, 1'b1, 32'h200, 1'b0);
    do_update(32'h100, 1'b1, 32'h220, 1'b0);
    do_update(32'h100, 1'b0, 32'h0,   1'b1);
    do_update(32'h300, 1'b0, 32'h0,   1'b0);
    do_update(32'h144, 1'b1, 32'h700, 1'b0);
    expect_lookup("b2b_100", 32'h100, 1'b1, 1'b1, 32'h220);
    expect_lookup("b2b_300", 32'h300, 1'b0, 1'b0, 32'h304);
    expect_lookup("b2b_144", 32'h144, 1'b1, 1'b1, 32'h700);
`ifdef BTP_STATS_EN
    checks++;
    if (stat_lookups !== 5 || stat_hits !== 2 || stat_mispredicts !== 1) begin
      fails++;
      $display("FAIL stats_counts got %0d/%0d/%0d expected 5/2/1", stat_lookups, stat_hits, stat_mispredicts);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_miss_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
